// File: rtl/sign_extend_pkg.sv
// Shared definitions for the immediate-extension unit and the control unit
// that drives ext_mode.
package sign_extend_pkg;

  // Default widths of the instruction immediate and the datapath word.
  localparam int IMM_W_DEF = 16;
  localparam int OUT_W_DEF = 32;

  // ext_mode encodings. EXT_RSVD decodes exactly like EXT_SIGN.
  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_RSVD = 2'b11;

endpackage : sign_extend_pkg

// File: rtl/sign_extend_imm_ext_core.sv
// Purely combinational mode mux: widens the immediate by sign-extension,
// zero-extension or LUI placement in the upper bits.
module sign_extend_imm_ext_core
  import sign_extend_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IMM_W-1:0] instr,
  input  logic [1:0]       ext_mode,
  output logic [OUT_W-1:0] ext_imm
);

  localparam int PAD_W = OUT_W - IMM_W;

  // Select the extension form; unknown/reserved encodings fall back to sign-extend.
  always_comb begin
    ext_imm = {{PAD_W{instr[IMM_W-1]}}, instr};
    case (ext_mode)
      EXT_ZERO: ext_imm = {{PAD_W{1'b0}}, instr};
      EXT_LUI:  ext_imm = {instr, {PAD_W{1'b0}}};
      default:  ext_imm = {{PAD_W{instr[IMM_W-1]}}, instr};
    endcase
  end

endmodule : sign_extend_imm_ext_core

// File: rtl/sign_extend.sv
// Immediate-extension unit of the single-cycle datapath. signimm and
// branch_off are combinational; signimm_q/q_valid are a capture register for
// pipelined or debug consumers and are the only clocked state.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IMM_W-1:0] instr,
  input  logic [1:0]       ext_mode,
  input  logic             load,
  output logic [OUT_W-1:0] signimm,
  output logic [OUT_W-1:0] branch_off,
  output logic [OUT_W-1:0] signimm_q,
  output logic             q_valid
);

  logic [OUT_W-1:0] signimm_d;
  logic             valid_d;
  logic             valid_q;

  sign_extend_imm_ext_core #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_core (
    .instr    (instr),
    .ext_mode (ext_mode),
    .ext_imm  (signimm)
  );

  // Word-to-byte offset for the branch adder; top two bits are simply dropped.
  assign branch_off = {signimm[OUT_W-3:0], 2'b00};

  // Next-state of the capture register: take the current result on load, else hold.
  always_comb begin
    signimm_d = signimm_q;
    valid_d   = valid_q;
    if (load) begin
      signimm_d = signimm;
      valid_d   = 1'b1;
    end
  end

  // Capture register; reset wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (reset) begin
      signimm_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      signimm_q <= signimm_d;
      valid_q   <= valid_d;
    end
  end

  assign q_valid = valid_q;

endmodule : sign_extend

// File: tb/tb_sign_extend.sv
// Directed bench for sign_extend: combinational modes, boundaries, and the
// capture register including reset/load collision.
module tb_sign_extend;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic [1:0]  ext_mode;
  logic        load;
  logic [31:0] signimm;
  logic [31:0] branch_off;
  logic [31:0] signimm_q;
  logic        q_valid;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  sign_extend dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .ext_mode   (ext_mode),
    .load       (load),
    .signimm    (signimm),
    .branch_off (branch_off),
    .signimm_q  (signimm_q),
    .q_valid    (q_valid)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_comb(input logic [1:0] mode, input logic [15:0] imm);
    ext_mode = mode;
    instr    = imm;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    instr    = 16'h0000;
    ext_mode = 2'b00;

    // Reset held for two edges.
    @(posedge clk); @(posedge clk); #1;
    check("rst_q", signimm_q, 32'h0);
    check("rst_valid", {31'b0, q_valid}, 32'h0);

    // Combinational sign-extend.
    set_comb(2'b00, 16'h5DD5);
    check("sx_5dd5", signimm, 32'h00005DD5);
    check("br_5dd5", branch_off, 32'h00017754);
    #30;
    set_comb(2'b00, 16'hFFFF);
    check("sx_ffff", signimm, 32'hFFFFFFFF);
    check("br_ffff", branch_off, 32'hFFFFFFFC);
    set_comb(2'b00, 16'h8000);
    check("sx_8000", signimm, 32'hFFFF8000);
    check("br_8000", branch_off, 32'hFFFE0000);
    set_comb(2'b00, 16'h7FFF);
    check("sx_7fff", signimm, 32'h00007FFF);
    set_comb(2'b11, 16'h8000);
    check("rsvd_8000", signimm, 32'hFFFF8000);
    set_comb(2'b11, 16'h7FFF);
    check("rsvd_7fff", signimm, 32'h00007FFF);

    // Zero-extend and LUI.
    set_comb(2'b01, 16'hFFFF);
    check("zx_ffff", signimm, 32'h0000FFFF);
    check("br_zx_ffff", branch_off, 32'h0003FFFC);
    set_comb(2'b01, 16'h8000);
    check("zx_8000", signimm, 32'h00008000);
    set_comb(2'b10, 16'h1234);
    check("lui_1234", signimm, 32'h12340000);
    check("br_lui_1234", branch_off, 32'h48D00000);

    // Register stage: release reset, confirm still clear.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_q", signimm_q, 32'h0);
    check("idle_valid", {31'b0, q_valid}, 32'h0);

    // Load ABCD sign-extended.
    @(negedge clk);
    ext_mode = 2'b00; instr = 16'hABCD; load = 1'b1;
    @(posedge clk); #1;
    check("load_q", signimm_q, 32'hFFFFABCD);
    check("load_valid", {31'b0, q_valid}, 32'h1);

    // Hold with load low while instr changes.
    @(negedge clk);
    load = 1'b0; instr = 16'h1111;
    @(posedge clk); #1;
    check("hold_q", signimm_q, 32'hFFFFABCD);
    check("hold_valid", {31'b0, q_valid}, 32'h1);
    check("hold_comb", signimm, 32'h00001111);
    @(posedge clk); #1;
    check("hold2_q", signimm_q, 32'hFFFFABCD);

    // Second load in LUI mode.
    @(negedge clk);
    ext_mode = 2'b10; instr = 16'h00FF; load = 1'b1;
    @(posedge clk); #1;
    check("load_lui_q", signimm_q, 32'h00FF0000);

    // Reset and load on the same edge: reset wins.
    @(negedge clk);
    ext_mode = 2'b00; instr = 16'h8000; reset = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    check("rl_q", signimm_q, 32'h0);
    check("rl_valid", {31'b0, q_valid}, 32'h0);
    check("rl_comb", signimm, 32'hFFFF8000);
    set_comb(2'b00, 16'h7FFF);
    check("rl_comb2", signimm, 32'h00007FFF);

    // Leave reset with load low: register stays clear.
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    check("post_q", signimm_q, 32'h0);
    check("post_valid", {31'b0, q_valid}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_sign_extend

// File: doc/sign_extend.md
Name: sign_extend

Overview:
- Immediate-extension unit of the single-cycle MIPS datapath.
- Widens the 16-bit instruction immediate to 32 bits: sign-extend, zero-extend, or LUI placement, selected by ext_mode.
- Primary output signimm is combinational, feeding the ALU B-mux and branch adder in the same cycle.
- A registered copy with a valid flag is also provided for pipelined or debug consumers; this is the only clocked state.

Parameters:
- IMM_W, 16, width of the input immediate field.
- OUT_W, 32, width of the extended result; must be greater than IMM_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  IMM_W  immediate field, instruction bits [15:0].
- ext_mode  input  2  00 sign-extend, 01 zero-extend, 10 LUI (imm << 16), 11 reserved (treated as sign-extend).
- load  input  1  capture the current result into the register stage.
- signimm  output  OUT_W  combinational extended immediate.
- branch_off  output  OUT_W  combinational signimm << 2, for branch target computation.
- signimm_q  output  OUT_W  registered extended immediate.
- q_valid  output  1  signimm_q holds captured data.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Sign-extend (mode 00 or 11): signimm = {(OUT_W-IMM_W){instr[IMM_W-1]}, instr}.
- Zero-extend (mode 01): signimm = {(OUT_W-IMM_W){1'b0}, instr}.
- LUI (mode 10): signimm = {instr, (OUT_W-IMM_W){1'b0}}.
- signimm and branch_off are purely combinational: zero latency, no dependence on clk or reset, valid whenever inputs are stable.
- branch_off = {signimm[OUT_W-3:0], 2'b00}; bits shifted out are discarded, no overflow flag.
- Register stage, on rising clk:
  - reset=1: signimm_q <= 0, q_valid <= 0. Reset has priority over load.
  - Else if load=1: signimm_q <= signimm, q_valid <= 1.
  - Else: hold both.
- q_valid stays 1 until the next reset.
- Reset asserted mid-operation clears the register stage on that edge only; the combinational outputs are unaffected.
- No X propagation: every mode decodes to a defined result.
- Boundaries:
  - instr=16'h8000 sign-extends to 32'hFFFF8000.
  - instr=16'h7FFF sign-extends to 32'h00007FFF.
  - instr=16'hFFFF sign-extends to all ones.

Decomposition:
- Shared package holds the ext_mode encodings (EXT_SIGN, EXT_ZERO, EXT_LUI) and the IMM_W/OUT_W defaults, so the control unit and this block agree.
- One natural sub-module: imm_ext_core, the purely combinational mode mux.
- The top level adds the branch shift and the load register.

Test Plan:
- Mode 00, instr=16'h5DD5 -> signimm=32'h00005DD5, branch_off=32'h00017754; then after 30 ns instr=16'hFFFF -> signimm=32'hFFFFFFFF, branch_off=32'hFFFFFFFC.
- Mode 00, instr=16'h8000 -> 32'hFFFF8000; instr=16'h7FFF -> 32'h00007FFF; mode 11 gives identical results.
- Mode 01, instr=16'hFFFF -> 32'h0000FFFF; mode 10, instr=16'h1234 -> 32'h12340000.
- reset=1 for 2 cycles -> signimm_q=0, q_valid=0. Then load=1 with instr=16'hABCD in mode 00 -> next edge signimm_q=32'hFFFFABCD, q_valid=1. load=0 with instr changed -> signimm_q holds.
- reset=1 and load=1 on the same edge -> signimm_q=0, q_valid=0, while signimm still tracks instr combinationally.
